// File: rtl/regfile_bram_ctrl_if.sv
// regfile_bram_ctrl_if: core-side write, read-request and read-response channels of the register file
interface regfile_bram_ctrl_if #(
  parameter int ADDR_W = 5,
  parameter int DATA_W = 32
);
  logic              wr_valid;
  logic              wr_ready;
  logic [ADDR_W-1:0] wr_addr;
  logic [DATA_W-1:0] wr_data;
  logic              rd_req_valid;
  logic              rd_req_ready;
  logic [ADDR_W-1:0] rs1_addr;
  logic [ADDR_W-1:0] rs2_addr;
  logic              rd_rsp_valid;
  logic              rd_rsp_ready;
  logic [DATA_W-1:0] rs1_data;
  logic [DATA_W-1:0] rs2_data;
  logic              busy;
  modport master (
    output wr_valid, wr_addr, wr_data, rd_req_valid, rs1_addr, rs2_addr, rd_rsp_ready,
    input  wr_ready, rd_req_ready, rd_rsp_valid, rs1_data, rs2_data, busy
  );
  modport slave (
    input  wr_valid, wr_addr, wr_data, rd_req_valid, rs1_addr, rs2_addr, rd_rsp_ready,
    output wr_ready, rd_req_ready, rd_rsp_valid, rs1_data, rs2_data, busy
  );
endinterface

// File: rtl/regfile_bram_ctrl.sv
// regfile_bram_ctrl: drives a dual-port BRAM as a 2-read/1-write register file with post-reset zero sweep
module regfile_bram_ctrl #(
  parameter int ADDR_W         = 5,
  parameter int DATA_W         = 32,
  parameter bit CLEAR_ON_RESET = 1,
  parameter bit ZERO_REG       = 1
) (
  input  logic              clk,
  input  logic              rst_n,
  regfile_bram_ctrl_if.slave core,
  output logic [ADDR_W-1:0] ram_ada,
  output logic [ADDR_W-1:0] ram_adb,
  output logic [DATA_W-1:0] ram_dina,
  output logic [DATA_W-1:0] ram_dinb,
  output logic              ram_wrea,
  output logic              ram_wreb,
  output logic              ram_cea,
  output logic              ram_ceb,
  output logic              ram_ocea,
  output logic              ram_oceb,
  output logic              ram_reseta,
  output logic              ram_resetb,
  input  logic [DATA_W-1:0] ram_douta,
  input  logic [DATA_W-1:0] ram_doutb
);
  typedef enum logic {CLEAR, RUN} state_t;
  localparam state_t INIT = CLEAR_ON_RESET ? CLEAR : RUN;
  state_t            state, state_nx;
  logic [ADDR_W-1:0] clr_cnt;
  logic              clr, run, wr_acc, rd_acc;
  logic              rsp_valid, fresh, z1, z2;
  logic [DATA_W-1:0] hold1, hold2, mux1, mux2;
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state   <= INIT;
      clr_cnt <= '0;
    end else begin
      state   <= state_nx;
      clr_cnt <= (state == CLEAR) ? clr_cnt + 1'b1 : '0;
    end
  end
  always_comb state_nx = (state == CLEAR && clr_cnt == '1) ? RUN : state;
  // reset is folded in so no RAM enable or ready is asserted while rst_n is low
  always_comb begin
    clr               = rst_n && state == CLEAR;
    run               = rst_n && state == RUN;
    core.busy         = clr;
    core.wr_ready     = run;
    core.rd_req_ready = run && !core.wr_valid && (!rsp_valid || core.rd_rsp_ready);
    wr_acc            = run && core.wr_valid;
    rd_acc            = core.rd_req_valid && core.rd_req_ready;
    ram_cea           = clr || wr_acc || rd_acc;
    ram_ceb           = rd_acc;
    ram_wrea          = clr || (wr_acc && !(ZERO_REG && core.wr_addr == '0));
    ram_wreb          = 1'b0;
    ram_ada           = clr ? clr_cnt : wr_acc ? core.wr_addr : core.rs1_addr;
    ram_adb           = core.rs2_addr;
    ram_dina          = wr_acc ? core.wr_data : '0;
    ram_dinb          = '0;
    ram_ocea          = 1'b1;
    ram_oceb          = 1'b1;
    ram_reseta        = 1'b0;
    ram_resetb        = 1'b0;
  end
  // RAM data is live only in the first response cycle; afterwards the hold copy is authoritative
  always_comb begin
    mux1              = fresh ? (z1 ? '0 : ram_douta) : hold1;
    mux2              = fresh ? (z2 ? '0 : ram_doutb) : hold2;
    core.rs1_data     = mux1;
    core.rs2_data     = mux2;
    core.rd_rsp_valid = rsp_valid;
  end
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rsp_valid <= 1'b0;
      fresh     <= 1'b0;
      z1        <= 1'b0;
      z2        <= 1'b0;
      hold1     <= '0;
      hold2     <= '0;
    end else begin
      rsp_valid <= rd_acc || (rsp_valid && !core.rd_rsp_ready);
      fresh     <= rd_acc;
      if (rd_acc) begin
        z1 <= ZERO_REG && core.rs1_addr == '0;
        z2 <= ZERO_REG && core.rs2_addr == '0;
      end
      if (fresh && !core.rd_rsp_ready) begin
        hold1 <= mux1;
        hold2 <= mux2;
      end
    end
  end
endmodule

// File: tb/tb_regfile_bram_ctrl.sv
// tb_regfile_bram_ctrl: directed checks of sweep, write/read paths, x0, hold buffer and mid-op reset
module tb_regfile_bram_ctrl;
  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic [4:0]  ram_ada, ram_adb;
  logic [31:0] ram_dina, ram_dinb, ram_douta, ram_doutb;
  logic        ram_wrea, ram_wreb, ram_cea, ram_ceb, ram_ocea, ram_oceb, ram_reseta, ram_resetb;
  logic [31:0] mem [32];
  int          total = 0;
  int          bad = 0;
  int          n;
  regfile_bram_ctrl_if #(.ADDR_W(5), .DATA_W(32)) bus ();
  regfile_bram_ctrl dut (
    .clk(clk), .rst_n(rst_n), .core(bus),
    .ram_ada(ram_ada), .ram_adb(ram_adb), .ram_dina(ram_dina), .ram_dinb(ram_dinb),
    .ram_wrea(ram_wrea), .ram_wreb(ram_wreb), .ram_cea(ram_cea), .ram_ceb(ram_ceb),
    .ram_ocea(ram_ocea), .ram_oceb(ram_oceb), .ram_reseta(ram_reseta), .ram_resetb(ram_resetb),
    .ram_douta(ram_douta), .ram_doutb(ram_doutb)
  );
  always #5 clk = ~clk;
  // behavioural dual-port RAM, 1-cycle read latency, write-through on port A
  always @(posedge clk) begin
    if (ram_cea) begin
      if (ram_wrea) mem[ram_ada] <= ram_dina;
      ram_douta <= ram_wrea ? ram_dina : mem[ram_ada];
    end
    if (ram_ceb) ram_doutb <= mem[ram_adb];
  end
  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask
  initial begin
    bus.wr_valid = 0; bus.wr_addr = 0; bus.wr_data = 0;
    bus.rd_req_valid = 0; bus.rs1_addr = 0; bus.rs2_addr = 0; bus.rd_rsp_ready = 0;
    repeat (3) @(negedge clk);
    #1;
    chk("rst_outs", {bus.busy, bus.wr_ready, bus.rd_req_ready, bus.rd_rsp_valid, ram_cea, ram_wrea, ram_ceb}, 0);
    chk("rst_rs1", bus.rs1_data, 0);
    chk("ties", {ram_ocea, ram_oceb, ram_reseta, ram_resetb, ram_wreb}, 5'b11000);
    // T1 sweep
    @(negedge clk);
    rst_n = 1;
    for (int i = 0; i < 32; i++) begin
      #1;
      chk("clr_ada", ram_ada, i);
      chk("clr_ctl", {bus.busy, ram_cea, ram_wrea, bus.wr_ready, bus.rd_req_ready, ram_dina != 0}, 6'b111000);
      @(negedge clk);
    end
    #1;
    chk("run_rdy", {bus.busy, bus.wr_ready, bus.rd_req_ready}, 3'b011);
    // T2 write then read
    @(negedge clk);
    bus.wr_valid = 1; bus.wr_addr = 5; bus.wr_data = 32'hDEADBEEF;
    #1;
    chk("t2_wr_port", {ram_cea, ram_wrea, 3'b0, ram_ada}, {2'b11, 3'b0, 5'd5});
    chk("t2_wr_din", ram_dina, 32'hDEADBEEF);
    @(negedge clk);
    bus.wr_valid = 0; bus.rd_req_valid = 1; bus.rs1_addr = 5; bus.rs2_addr = 0;
    #1;
    chk("t2_rd_port", {bus.rd_req_ready, ram_cea, ram_ceb, ram_wrea, 3'b0, ram_ada}, {4'b1110, 3'b0, 5'd5});
    @(negedge clk);
    bus.rd_req_valid = 0; bus.rd_rsp_ready = 1;
    #1;
    chk("t2_valid", bus.rd_rsp_valid, 1);
    chk("t2_rs1", bus.rs1_data, 32'hDEADBEEF);
    chk("t2_rs2", bus.rs2_data, 0);
    chk("t2_idle", {ram_cea, ram_ceb}, 0);
    @(negedge clk);
    #1;
    chk("t2_drop", bus.rd_rsp_valid, 0);
    // T3 write wins over simultaneous read
    @(negedge clk);
    bus.wr_valid = 1; bus.wr_addr = 9; bus.wr_data = 32'h55;
    bus.rd_req_valid = 1; bus.rs1_addr = 9; bus.rs2_addr = 5;
    #1;
    chk("t3_arb", {bus.wr_ready, bus.rd_req_ready, ram_wrea, ram_ceb}, 4'b1010);
    chk("t3_ada", ram_ada, 9);
    @(negedge clk);
    bus.wr_valid = 0;
    #1;
    chk("t3_rd_acc", {bus.rd_req_ready, ram_ceb}, 2'b11);
    @(negedge clk);
    bus.rd_req_valid = 0;
    #1;
    chk("t3_valid", bus.rd_rsp_valid, 1);
    chk("t3_rs1", bus.rs1_data, 32'h55);
    chk("t3_rs2", bus.rs2_data, 32'hDEADBEEF);
    // T4 x0 writes discarded
    @(negedge clk);
    bus.wr_valid = 1; bus.wr_addr = 0; bus.wr_data = 32'h1234;
    #1;
    chk("t4_wr_x0", {bus.wr_ready, ram_cea, ram_wrea}, 3'b110);
    @(negedge clk);
    bus.wr_valid = 0; bus.rd_req_valid = 1; bus.rs1_addr = 0; bus.rs2_addr = 0;
    @(negedge clk);
    bus.rd_req_valid = 0;
    #1;
    chk("t4_valid", bus.rd_rsp_valid, 1);
    chk("t4_rs", {bus.rs1_data, bus.rs2_data} != 0, 0);
    // T5 hold buffer while a later write overwrites the register
    @(negedge clk);
    bus.wr_valid = 1; bus.wr_addr = 7; bus.wr_data = 32'hA5A5A5A5;
    @(negedge clk);
    bus.wr_valid = 0; bus.rd_req_valid = 1; bus.rs1_addr = 7; bus.rs2_addr = 9; bus.rd_rsp_ready = 0;
    @(negedge clk);
    bus.rd_req_valid = 0; bus.wr_valid = 1; bus.wr_addr = 7; bus.wr_data = 32'h1;
    #1;
    chk("t5_v0", bus.rd_rsp_valid, 1);
    chk("t5_rs1_0", bus.rs1_data, 32'hA5A5A5A5);
    chk("t5_rs2_0", bus.rs2_data, 32'h55);
    @(negedge clk);
    bus.wr_valid = 0; bus.rd_req_valid = 1; bus.rs1_addr = 7; bus.rs2_addr = 0;
    #1;
    chk("t5_rs1_1", bus.rs1_data, 32'hA5A5A5A5);
    chk("t5_blk_1", {bus.rd_rsp_valid, bus.rd_req_ready}, 2'b10);
    @(negedge clk);
    #1;
    chk("t5_rs1_2", bus.rs1_data, 32'hA5A5A5A5);
    chk("t5_rs2_2", bus.rs2_data, 32'h55);
    chk("t5_blk_2", {bus.rd_rsp_valid, bus.rd_req_ready}, 2'b10);
    @(negedge clk);
    bus.rd_rsp_ready = 1;
    #1;
    chk("t5_take", {bus.rd_rsp_valid, bus.rd_req_ready}, 2'b11);
    chk("t5_rs1_3", bus.rs1_data, 32'hA5A5A5A5);
    @(negedge clk);
    bus.rd_req_valid = 0;
    #1;
    chk("t5_b2b", bus.rd_rsp_valid, 1);
    chk("t5_new", bus.rs1_data, 32'h1);
    @(negedge clk);
    #1;
    chk("t5_drop", bus.rd_rsp_valid, 0);
    // T6 reset with a pending response
    @(negedge clk);
    bus.rd_req_valid = 1; bus.rs1_addr = 5; bus.rs2_addr = 7; bus.rd_rsp_ready = 0;
    @(negedge clk);
    bus.rd_req_valid = 0;
    #1;
    chk("t6_pend", {bus.rd_rsp_valid, bus.rs1_data}, {1'b1, 32'hDEADBEEF});
    rst_n = 0;
    #1;
    chk("t6_drop", {bus.rd_rsp_valid, bus.rs1_data}, 0);
    @(negedge clk);
    rst_n = 1;
    bus.rd_rsp_ready = 1;
    #1;
    n = 0;
    while (bus.busy && n < 40) begin
      @(negedge clk);
      #1;
      n++;
    end
    chk("t6_sweep_len", n, 32);
    @(negedge clk);
    bus.rd_req_valid = 1; bus.rs1_addr = 5; bus.rs2_addr = 7;
    @(negedge clk);
    bus.rd_req_valid = 0;
    #1;
    chk("t6_valid", bus.rd_rsp_valid, 1);
    chk("t6_rs1", bus.rs1_data, 0);
    chk("t6_rs2", bus.rs2_data, 0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
